// File: rtl/io_out_pkg.sv
// rtl/io_out_pkg.sv - shared encodings and helpers for the I/O output port bank
// Write-op codes, status field offsets and byte-enable mask expansion.
package io_out_pkg;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  localparam int ST_VALID_LSB = 0;
  localparam int ST_OVR_LSB   = 16;

  // Lanes at or above dw/8 never contribute, so narrow ports ignore high enables.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be, input int dw);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      if ((b < dw / 8) && be[b]) begin
        m[b*8 +: 8] = 8'hFF;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/io_out_port_slice.sv
// rtl/io_out_port_slice.sv - one output port: data register, valid flag, sticky overrun
// Applies WR/SET/CLR/TGL under a byte mask and tracks the consumer handshake.
module io_out_port_slice
  import io_out_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          io_clk,
  input  logic          clrn,
  input  logic          hit,
  input  logic [1:0]    op,
  input  logic [DW-1:0] mask,
  input  logic [DW-1:0] data,
  input  logic          ack,
  input  logic          ovr_clr,
  output logic [DW-1:0] port_data,
  output logic          port_valid,
  output logic          port_ovr
);

  logic [DW-1:0] data_d, data_q;
  logic          valid_d, valid_q;
  logic          ovr_d, ovr_q;
  logic [DW-1:0] dm;
  logic          ovr_set;

  always_comb begin
    dm     = data & mask;
    data_d = data_q;
    if (hit) begin
      case (op)
        OP_WR:   data_d = (data_q & ~mask) | dm;
        OP_SET:  data_d = data_q | dm;
        OP_CLR:  data_d = data_q & ~dm;
        default: data_d = data_q ^ dm;
      endcase
    end
  end

  // A write wins over a same-cycle ack; an unacknowledged write on pending data overruns.
  always_comb begin
    valid_d = valid_q;
    if (hit) begin
      valid_d = 1'b1;
    end else if (ack) begin
      valid_d = 1'b0;
    end
    ovr_set = hit & valid_q & ~ack;
    ovr_d   = ovr_set | (ovr_q & ~ovr_clr);
  end

  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign port_data  = data_q;
  assign port_valid = valid_q;
  assign port_ovr   = ovr_q;

endmodule

// File: rtl/io_output_bank.sv
// rtl/io_output_bank.sv - memory-mapped output port bank with status and read-back
// Decodes the MEM-stage I/O bus into port slices, a W1C status register and a read mux.
module io_output_bank
  import io_out_pkg::*;
#(
  parameter int         NPORTS   = 3,
  parameter int         DW       = 32,
  parameter logic [5:0] BASE_IDX = 6'h23
) (
  input  logic                 io_clk,
  input  logic                 clrn,
  input  logic [31:0]          addr,
  input  logic [31:0]          datain,
  input  logic [3:0]           be,
  input  logic                 write_io_enable,
  input  logic                 read_io_enable,
  input  logic [NPORTS-1:0]    port_ack,
  output logic [NPORTS*DW-1:0] out_port,
  output logic [NPORTS-1:0]    port_valid,
  output logic [31:0]          rd_data,
  output logic                 rd_hit
);

  logic [5:0]        idx;
  logic              port_hit;
  logic              st_hit;
  logic [1:0]        wr_op;
  logic [31:0]       mask_full;
  logic [DW-1:0]     mask;
  logic [NPORTS-1:0] wr_hit;
  logic [NPORTS-1:0] ovr_clr;
  logic [NPORTS-1:0] ovr;
  logic [DW-1:0]     port_data [NPORTS];
  logic              unused_bits;

  // Subtraction wraps on 6 bits, so addresses below the base land far out of range.
  assign idx       = addr[7:2] - BASE_IDX;
  assign port_hit  = {1'b0, idx} < 7'(NPORTS);
  assign st_hit    = {1'b0, idx} == 7'(NPORTS);
  assign wr_op     = addr[9:8];
  assign mask_full = be_to_mask(be, DW);
  assign mask      = mask_full[DW-1:0];

  assign unused_bits = ^{addr[31:10], addr[1:0], mask_full};

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    // Status clears use the full 32-bit lane enables, independent of port width.
    assign wr_hit[i]  = write_io_enable & port_hit & (idx == 6'(i));
    assign ovr_clr[i] = write_io_enable & st_hit & datain[ST_OVR_LSB + i]
                        & be[(ST_OVR_LSB + i) / 8];

    io_out_port_slice #(
      .DW(DW)
    ) u_slice (
      .io_clk    (io_clk),
      .clrn      (clrn),
      .hit       (wr_hit[i]),
      .op        (wr_op),
      .mask      (mask),
      .data      (datain[DW-1:0]),
      .ack       (port_ack[i]),
      .ovr_clr   (ovr_clr[i]),
      .port_data (port_data[i]),
      .port_valid(port_valid[i]),
      .port_ovr  (ovr[i])
    );

    assign out_port[i*DW +: DW] = port_data[i];
  end

  logic [31:0] rd_val;
  logic        rd_hit_val;
  logic [31:0] rd_data_d, rd_data_q;
  logic        rd_hit_d, rd_hit_q;

  // Reads see pre-edge register state, so a same-cycle write is not visible yet.
  always_comb begin
    rd_val     = '0;
    rd_hit_val = 1'b0;
    if (port_hit) begin
      rd_hit_val = 1'b1;
      for (int i = 0; i < NPORTS; i++) begin
        if (idx == 6'(i)) begin
          rd_val[DW-1:0] = port_data[i];
        end
      end
    end else if (st_hit) begin
      rd_hit_val = 1'b1;
      rd_val[ST_VALID_LSB +: NPORTS] = port_valid;
      rd_val[ST_OVR_LSB +: NPORTS]   = ovr;
    end
    rd_data_d = read_io_enable ? rd_val : rd_data_q;
    rd_hit_d  = read_io_enable ? rd_hit_val : rd_hit_q;
  end

  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_hit_q  <= rd_hit_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_hit  = rd_hit_q;

endmodule

// File: doc/io_output_bank.md
# io_output_bank

Parametrised memory-mapped output port bank for the pipelined CPU's I/O space. It replaces the fixed three-register output block and adds:
- a configurable number and width of ports;
- byte-enabled and set/clear/toggle writes;
- registered read-back;
- a per-port valid/ack handshake with sticky overrun status.

It sits on the MEM-stage I/O bus beside the input port block, clocked by `io_clk`.

## Interface
Parameters:
- `NPORTS`, 3: number of output ports, 1..16.
- `DW`, 32: port width, one of 8/16/32. Uses the low `DW` bits of `datain`.
- `BASE_IDX`, 6'h23: value of `addr[7:2]` that selects port 0. Port i is at `BASE_IDX+i`. The status register is at `BASE_IDX+NPORTS`.

Ports:
- `io_clk`  in  1  I/O clock; all state updates on its rising edge.
- `clrn`  in  1  asynchronous active-low reset.
- `addr`  in  32  byte address. `addr[7:2]` is the word index and `addr[9:8]` is the write op. Other bits are ignored.
- `datain`  in  32  write data.
- `be`  in  4  byte enables. Bits at or above `DW/8` are ignored.
- `write_io_enable`  in  1  write strobe, one cycle.
- `read_io_enable`  in  1  read strobe, one cycle.
- `port_ack`  in  NPORTS  per-port consumer acknowledge.
- `out_port`  out  NPORTS*DW  flat port data; port i occupies `[i*DW +: DW]`.
- `port_valid`  out  NPORTS  per-port "new data" flag.
- `rd_data`  out  32  registered read-back data.
- `rd_hit`  out  1  registered read hit: the last read decoded to a port or to status.

## Operation
- **Decode:** `idx = addr[7:2] - BASE_IDX`, computed on 6 bits.
  - Port hit: `idx < NPORTS`.
  - Status hit: `idx == NPORTS`.
  - Anything else is a miss: no state change, and a read returns 0 with `rd_hit = 0`.
- **Byte mask:** `m` expands `be` to `DW` bits. With `d = datain[DW-1:0] & m`, a port write applies op `addr[9:8]`:
  - 00 WR: `(old & ~m) | d`
  - 01 SET: `old | d`
  - 10 CLR: `old & ~d`
  - 11 TGL: `old ^ d`
- **Handshake, per port:**
  - Any port write sets `port_valid[i]`, even if the value is unchanged.
  - `port_ack[i]` clears `port_valid[i]`; an ack while valid is 0 has no effect.
  - Write and ack in the same cycle: valid stays 1 and overrun is not set.
  - Write while valid is 1 and no ack in that cycle: sets sticky `ovr[i]`.
- **Status register read:**
  - `[NPORTS-1:0]` = `port_valid`.
  - `[16+NPORTS-1:16]` = `ovr`.
  - All other bits read 0.
- **Status register write:** W1C on the `ovr` bits, gated by `be` byte lanes; the op field is ignored. Valid bits are read-only.
  - A W1C clear and a new overrun on the same bit in the same cycle: set wins.
- **Read:** on `read_io_enable`, `rd_data` and `rd_hit` load the decoded value on the next edge. Both hold until the next read.
- **Same-cycle read and write:** a read of the register being written returns the pre-write value.
- **Reset:** while `clrn` is low, all of these are 0: `out_port`, `port_valid`, `ovr`, `rd_data`, `rd_hit`.
  - Reset asserted mid-operation clears everything immediately and asynchronously.
  - An in-flight write in the reset-release cycle is lost if `clrn` is still low at the edge.

## Timing
- Write latency: `out_port` and `port_valid` update at the rising edge where `write_io_enable` = 1 and are visible after that edge (1 cycle).
- Read latency: 1 cycle, from the `read_io_enable` edge to `rd_data`/`rd_hit`.
- Ack clears valid at the edge where `port_ack` is sampled high.
- No combinational path from any input to any output.
- Back-to-back writes every cycle are supported, each applying to the current register value.

## Structure
- **Package `io_out_pkg`:**
  - op encodings `OP_WR`/`OP_SET`/`OP_CLR`/`OP_TGL`;
  - status field offsets (`ST_VALID_LSB` = 0, `ST_OVR_LSB` = 16);
  - function `be_to_mask(be, DW)`.
- **Sub-module `io_out_port_slice`**, instantiated `NPORTS` times with a generate loop. It holds one port's data register, valid flag and overrun bit, and its inputs are hit, op, mask, data, ack and ovr_clr.
- **Top level:** decode, status W1C fan-out and the registered read mux.

## Test plan
- **Reset and basic write:** assert reset, then write `WR addr 0x8C data 0x12345678 be 1111` -> `out_port[0]` = 0x12345678 and `port_valid` = 3'b001; other ports stay 0.
- **Byte enable and ops, port 1 (0x90):**
  - write 0xAABBCCDD, be 0011 -> 0x0000CCDD;
  - SET at 0x190 with 0xF0000000, be 1000 -> 0xF000CCDD;
  - TGL at 0x390 with 0x000000FF, be 0001 -> 0xF000CC22.
- **Handshake on port 2 (0x94):**
  - write, then write again with no ack -> `ovr[2]` = 1, status read at 0x98 = 0x00040004;
  - write with ack in the same cycle -> valid stays 1 and `ovr` is unchanged.
- **Overrun W1C:** write 0x00040000 to 0x98 -> `ovr` cleared. Repeat with a simultaneous new overrun -> `ovr[2]` remains 1.
- **Read-back:**
  - read 0x8C in the same cycle as a write of 0x1 -> `rd_data` = old value, `rd_hit` = 1;
  - read 0xA0 -> `rd_data` = 0, `rd_hit` = 0.
- **Mid-operation reset:** pulse `clrn` low between the edges of a write burst -> all outputs are 0 immediately; the next write after release behaves as the first write.
